frame_reader_vga: RTL and testbench

//  Read side of the frame buffer: walks the stored image in raster order,

---
 rtl/frame_reader_vga_if.sv | 27 ++
 rtl/frame_reader_vga.sv | 150 +++++++++++++++
 tb/tb_frame_reader_vga.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/frame_reader_vga_if.sv
// rtl/frame_reader_vga_if.sv - frame buffer read port plus VGA pixel/sync outputs
interface frame_reader_vga_if #(
    parameter int NB_ADDR = 15,
    parameter int NB_BUF  = 12
);
    logic [NB_ADDR-1:0] addrb;
    logic [NB_BUF-1:0]  doutb;
    logic [3:0]         vga_red;
    logic [3:0]         vga_green;
    logic [3:0]         vga_blue;
    logic               vga_hsync;
    logic               vga_vsync;
    logic               visible;
    logic               frame_end;

    modport master (
        output addrb,
        input  doutb,
        output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, visible, frame_end
    );

    modport slave (
        input  addrb,
        output doutb,
        input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, visible, frame_end
    );
endinterface

// File: rtl/frame_reader_vga.sv
// rtl/frame_reader_vga.sv - raster frame buffer reader with VGA timing; FRAME_READER_ZOOM_EN enables c_zoom pixel replication
module frame_reader_vga #(
    parameter int c_img_cols     = 160,
    parameter int c_img_rows     = 120,
    parameter int c_nb_img_pxls  = $clog2(c_img_cols*c_img_rows),
    parameter int c_nb_buf       = 12,
    parameter int c_pxl_visible  = 640,
    parameter int c_pxl_fporch   = 16,
    parameter int c_pxl_synch    = 96,
    parameter int c_pxl_bporch   = 48,
    parameter int c_line_visible = 480,
    parameter int c_line_fporch  = 10,
    parameter int c_line_synch   = 2,
    parameter int c_line_bporch  = 33,
`ifdef FRAME_READER_ZOOM_EN
    parameter int c_zoom         = 4,
`endif
    parameter logic c_sync_pol   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    frame_reader_vga_if.master    bus
);
    localparam int PXL_TOTAL  = c_pxl_visible + c_pxl_fporch + c_pxl_synch + c_pxl_bporch;
    localparam int LINE_TOTAL = c_line_visible + c_line_fporch + c_line_synch + c_line_bporch;
    localparam int NB_P       = $clog2(PXL_TOTAL);
    localparam int NB_L       = $clog2(LINE_TOTAL);
    localparam int HS_START   = c_pxl_visible + c_pxl_fporch;
    localparam int VS_START   = c_line_visible + c_line_fporch;
`ifdef FRAME_READER_ZOOM_EN
    localparam int ZOOM       = c_zoom;
    localparam int NB_Z       = $clog2(c_zoom + 1);
`else
    localparam int ZOOM       = 1;
`endif
    localparam int IMG_W      = c_img_cols * ZOOM;
    localparam int IMG_H      = c_img_rows * ZOOM;
    localparam int NB_A       = c_nb_img_pxls;

    logic [NB_P-1:0] cnt_pxl_q, cnt_pxl_d;
    logic [NB_L-1:0] cnt_line_q, cnt_line_d;
    logic [NB_A-1:0] addrb_q, addrb_d;
    logic [NB_A-1:0] nxt_q, nxt_d;
    // Stage flags packed as {in_image, visible, hsync_act, vsync_act, frame_end}
    logic [4:0]      st0, st1_q, st2_q;
    int              p, l;
    logic            line_end, frame_wrap, in_img0;

`ifdef FRAME_READER_ZOOM_EN
    logic [NB_Z-1:0] col_sub_q, col_sub_d, row_sub_q, row_sub_d;
    logic [NB_A-1:0] base_q, base_d, nxt_inc;
`endif

    assign p = int'(cnt_pxl_q);
    assign l = int'(cnt_line_q);

    always_comb begin
        line_end   = (p == PXL_TOTAL - 1);
        frame_wrap = line_end && (l == LINE_TOTAL - 1);
        cnt_pxl_d  = line_end ? '0 : cnt_pxl_q + NB_P'(1);
        cnt_line_d = cnt_line_q;
        if (line_end) begin
            cnt_line_d = frame_wrap ? '0 : cnt_line_q + NB_L'(1);
        end
        in_img0 = (p < IMG_W) && (l < IMG_H);
        st0 = {in_img0,
               (p < c_pxl_visible) && (l < c_line_visible),
               (p >= HS_START) && (p < HS_START + c_pxl_synch),
               (l >= VS_START) && (l < VS_START + c_line_synch),
               (p == 0) && (l == c_line_visible)};
    end

    // Address walks as a plain counter; no row*cols multiply is needed.
    always_comb begin
        addrb_d = addrb_q;
        nxt_d   = nxt_q;
`ifdef FRAME_READER_ZOOM_EN
        col_sub_d = col_sub_q;
        row_sub_d = row_sub_q;
        base_d    = base_q;
        nxt_inc   = (int'(col_sub_q) == ZOOM - 1) ? nxt_q + NB_A'(1) : nxt_q;
        if (frame_wrap) begin
            addrb_d   = '0;
            nxt_d     = '0;
            col_sub_d = '0;
            row_sub_d = '0;
            base_d    = '0;
        end else if (in_img0) begin
            addrb_d   = nxt_q;
            nxt_d     = nxt_inc;
            col_sub_d = (int'(col_sub_q) == ZOOM - 1) ? '0 : col_sub_q + NB_Z'(1);
            if (p == IMG_W - 1) begin
                if (int'(row_sub_q) == ZOOM - 1) begin
                    row_sub_d = '0;
                    base_d    = nxt_inc;
                end else begin
                    row_sub_d = row_sub_q + NB_Z'(1);
                    nxt_d     = base_q;
                end
            end
        end
`else
        if (frame_wrap) begin
            addrb_d = '0;
            nxt_d   = '0;
        end else if (in_img0) begin
            addrb_d = nxt_q;
            nxt_d   = nxt_q + NB_A'(1);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_pxl_q  <= '0;
            cnt_line_q <= '0;
            addrb_q    <= '0;
            nxt_q      <= '0;
            st1_q      <= '0;
            st2_q      <= '0;
`ifdef FRAME_READER_ZOOM_EN
            col_sub_q  <= '0;
            row_sub_q  <= '0;
            base_q     <= '0;
`endif
        end else begin
            cnt_pxl_q  <= cnt_pxl_d;
            cnt_line_q <= cnt_line_d;
            addrb_q    <= addrb_d;
            nxt_q      <= nxt_d;
            st1_q      <= st0;
            st2_q      <= st1_q;
`ifdef FRAME_READER_ZOOM_EN
            col_sub_q  <= col_sub_d;
            row_sub_q  <= row_sub_d;
            base_q     <= base_d;
`endif
        end
    end

    // RAM data arrives alongside stage 2, so RGB is gated straight from doutb.
    assign bus.addrb     = addrb_q;
    assign bus.vga_red   = st2_q[4] ? bus.doutb[11:8] : 4'h0;
    assign bus.vga_green = st2_q[4] ? bus.doutb[7:4]  : 4'h0;
    assign bus.vga_blue  = st2_q[4] ? bus.doutb[3:0]  : 4'h0;
    assign bus.visible   = st2_q[3];
    assign bus.vga_hsync = st2_q[2] ? c_sync_pol : ~c_sync_pol;
    assign bus.vga_vsync = st2_q[1] ? c_sync_pol : ~c_sync_pol;
    assign bus.frame_end = st2_q[0];
endmodule

// File: tb/tb_frame_reader_vga.sv
// tb/tb_frame_reader_vga.sv - scoreboard bench for frame_reader_vga on reduced VGA timing
module tb_frame_reader_vga;
    localparam int COLS = 10, ROWS = 6, NB_A = 6;
    localparam int PV = 40, PF = 4, PS = 6, PB = 4;
    localparam int LV = 30, LF = 2, LS = 2, LB = 3;
    localparam int HT = PV + PF + PS + PB;
    localparam int VT = LV + LF + LS + LB;
    localparam int FRAME = HT * VT;
`ifdef FRAME_READER_ZOOM_EN
    localparam int Z = 4;
`else
    localparam int Z = 1;
`endif

    typedef struct packed {
        logic            chk_a;
        logic [NB_A-1:0] a;
        logic [11:0]     rgb;
        logic            hs, vs, vis, fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] mem [64];
    exp_t q[$];
    exp_t blank;
    int vectors = 0, miscompares = 0, nprint = 0;
    int cyc = 0, fe_seen = 0, fe_exp = 0;
    int mp, ml;
    logic [NB_A-1:0] maddr;
    logic [NB_A-1:0] prev_addrb = '0;

    always #5 clk = ~clk;

    frame_reader_vga_if #(.NB_ADDR(NB_A), .NB_BUF(12)) ifc ();

    frame_reader_vga #(
        .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_img_pxls(NB_A), .c_nb_buf(12),
        .c_pxl_visible(PV), .c_pxl_fporch(PF), .c_pxl_synch(PS), .c_pxl_bporch(PB),
        .c_line_visible(LV), .c_line_fporch(LF), .c_line_synch(LS), .c_line_bporch(LB)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(ifc)
    );

    always @(posedge clk) begin
        ifc.doutb <= mem[ifc.addrb];
        cyc <= cyc + 1;
    end

    function automatic exp_t expect_at(int p, int l, logic [NB_A-1:0] held);
        exp_t e;
        bit inimg;
        int idx;
        inimg = (p < COLS * Z) && (l < ROWS * Z);
        idx = (l / Z) * COLS + p / Z;
        e.chk_a = 1'b1;
        if (inimg) e.a = NB_A'(idx);
        else if (p == HT - 1 && l == VT - 1) e.a = '0;
        else e.a = held;
        e.rgb = inimg ? mem[idx] : 12'h000;
        e.hs  = (p >= PV + PF) && (p < PV + PF + PS);
        e.vs  = (l >= LV + LF) && (l < LV + LF + LS);
        e.vis = (p < PV) && (l < LV);
        e.fe  = (p == 0) && (l == LV);
        return e;
    endfunction

    // Reference: every counter position is scored; outputs trail it by two clocks.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            q.push_back(blank);
            q.push_back(blank);
            mp = 0;
            ml = 0;
            maddr = '0;
            e = expect_at(0, 0, maddr);
            maddr = e.a;
            q.push_back(e);
        end else if (q.size() > 0) begin
            mp = mp + 1;
            if (mp == HT) begin
                mp = 0;
                ml = (ml + 1) % VT;
            end
            e = expect_at(mp, ml, maddr);
            maddr = e.a;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic [11:0] rgb;
        if (q.size() >= 3) begin
            e = q.pop_front();
            rgb = {ifc.vga_red, ifc.vga_green, ifc.vga_blue};
            vectors++;
            if (e.fe) fe_exp++;
            if (ifc.frame_end) fe_seen++;
            if (rgb !== e.rgb || ifc.vga_hsync !== ~e.hs || ifc.vga_vsync !== ~e.vs ||
                ifc.visible !== e.vis || ifc.frame_end !== e.fe ||
                (e.chk_a && prev_addrb !== e.a)) begin
                miscompares++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL pixel cyc=%0d got/want rgb=%h/%h hs=%b/%b vs=%b/%b vis=%b/%b fe=%b/%b addrb=%0d/%0d",
                             cyc, rgb, e.rgb, ifc.vga_hsync, ~e.hs, ifc.vga_vsync, ~e.vs,
                             ifc.visible, e.vis, ifc.frame_end, e.fe, prev_addrb, e.a);
                end
            end
        end
        prev_addrb = ifc.addrb;
    end

    task automatic check_reset(input string name);
        logic [11:0] rgb;
        rgb = {ifc.vga_red, ifc.vga_green, ifc.vga_blue};
        vectors++;
        if (rgb !== 12'h000 || ifc.visible !== 1'b0 || ifc.vga_hsync !== 1'b1 ||
            ifc.vga_vsync !== 1'b1 || ifc.addrb !== '0 || ifc.frame_end !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got rgb=%h vis=%b hs=%b vs=%b addrb=%0d fe=%b want 000 0 1 1 0 0",
                     name, rgb, ifc.visible, ifc.vga_hsync, ifc.vga_vsync, ifc.addrb, ifc.frame_end);
        end
    endtask

    initial begin
        int rel;
        bit found;
        blank = '0;
        for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("reset_hold");
        rst_n = 1'b1;
        repeat (2 * FRAME + $urandom_range(0, FRAME / 2)) @(negedge clk);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_mid");
        rst_n = 1'b1;
        rel = cyc;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (ifc.frame_end) found = 1'b1;
        end
        vectors++;
        if (!found || cyc - rel != LV * HT + 2) begin
            miscompares++;
            $display("FAIL frame_end_gap got found=%0d gap=%0d want %0d", found, cyc - rel, LV * HT + 2);
        end

        repeat (FRAME / 2) @(negedge clk);
        vectors++;
        if (fe_seen != fe_exp || fe_exp < 3) begin
            miscompares++;
            $display("FAIL frame_end_count got %0d want %0d (at least 3)", fe_seen, fe_exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
